// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: FSM states, request
// opcodes and the ALU control encodings driven onto ALUCtrl.
package alu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_PASSB = 3'b100;
  localparam logic [2:0] OP_CBZ   = 3'b101;
  localparam logic [2:0] OP_CBNZ  = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_OR    = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_PASSB = 4'b0111;

  // CBZ/CBNZ let the ALU pass B through so its Zero flag tests B==0.
  function automatic logic [3:0] op_to_ctrl(input logic [2:0] op);
    logic [3:0] ctrl;
    ctrl = CTRL_PASSB;
    case (op)
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      default: ctrl = CTRL_PASSB;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_wait_counter.sv
// Down-counter that times how long the ALU inputs are held stable.
// Loaded with ALU_LAT-1 on accept; done flags the last hold cycle in EXEC.
module alu_wait_counter #(
  parameter int ALU_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [3:0] count;

  // Load on accept, then count down while the ALU is evaluating.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(ALU_LAT - 1);
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = en && (count == 4'd0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the combinational ALU: registers one
// request onto the ALU buses, holds them ALU_LAT cycles, samples the result
// and returns it on a valid/ready response port. One operation in flight.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int n       = 64,
  parameter int ALU_LAT = 2,
  parameter int TAGW    = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic [2:0]      ReqOp,
  input  logic [n-1:0]    ReqA,
  input  logic [n-1:0]    ReqB,
  input  logic [TAGW-1:0] ReqTag,
  output logic [3:0]      ALUCtrl,
  output logic [n-1:0]    ALUBusA,
  output logic [n-1:0]    ALUBusB,
  input  logic [n-1:0]    ALUBusW,
  input  logic            ALUZero,
  output logic            RspValid,
  input  logic            RspReady,
  output logic [n-1:0]    RspData,
  output logic            RspZero,
  output logic            RspTaken,
  output logic            RspErr,
  output logic [TAGW-1:0] RspTag
);

  state_t          state, state_next;
  logic            accept, illegal, done;

  logic [3:0]      ctrl_p1;
  logic [n-1:0]    bus_a_p1, bus_b_p1;
  logic [2:0]      op_p1;
  logic [TAGW-1:0] tag_p1;

  logic [n-1:0]    rsp_data_p2;
  logic            rsp_zero_p2, rsp_taken_p2, rsp_err_p2;

  // Branch resolution from the sampled zero flag.
  function automatic logic branch_taken(input logic [2:0] op, input logic zero);
    logic taken;
    taken = 1'b0;
    if (op == OP_CBZ)  taken = zero;
    if (op == OP_CBNZ) taken = ~zero;
    return taken;
  endfunction

  assign ReqReady = (state == IDLE) || ((state == RESP) && RspReady);
  assign accept   = ReqValid && ReqReady;
  assign illegal  = (ReqOp == OP_ILL);

  alu_wait_counter #(
    .ALU_LAT (ALU_LAT)
  ) u_wait (
    .clk  (CLK),
    .rst  (Reset),
    .load (accept && !illegal),
    .en   (state == EXEC),
    .done (done)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; an illegal op skips the ALU wait entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = illegal ? RESP : EXEC;
      EXEC: if (done)   state_next = RESP;
      RESP: begin
        if (RspReady) state_next = accept ? (illegal ? RESP : EXEC) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage 1: operand/control capture on accept, response capture on sample.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ctrl_p1      <= CTRL_PASSB;
      bus_a_p1     <= '0;
      bus_b_p1     <= '0;
      op_p1        <= '0;
      tag_p1       <= '0;
      rsp_data_p2  <= '0;
      rsp_zero_p2  <= 1'b0;
      rsp_taken_p2 <= 1'b0;
      rsp_err_p2   <= 1'b0;
    end else begin
      if (accept && !illegal) begin
        ctrl_p1  <= op_to_ctrl(ReqOp);
        bus_a_p1 <= ReqA;
        bus_b_p1 <= ReqB;
      end
      if (accept) begin
        op_p1  <= ReqOp;
        tag_p1 <= ReqTag;
      end
      // Stage 2: result sampled after ALU_LAT stable cycles
      if ((state == EXEC) && done) begin
        rsp_data_p2  <= ALUBusW;
        rsp_zero_p2  <= ALUZero;
        rsp_taken_p2 <= branch_taken(op_p1, ALUZero);
        rsp_err_p2   <= 1'b0;
      end else if (accept && illegal) begin
        rsp_data_p2  <= '0;
        rsp_zero_p2  <= 1'b0;
        rsp_taken_p2 <= 1'b0;
        rsp_err_p2   <= 1'b1;
      end
    end
  end

  assign ALUCtrl  = ctrl_p1;
  assign ALUBusA  = bus_a_p1;
  assign ALUBusB  = bus_b_p1;
  assign RspValid = (state == RESP);
  assign RspData  = rsp_data_p2;
  assign RspZero  = rsp_zero_p2;
  assign RspTaken = rsp_taken_p2;
  assign RspErr   = rsp_err_p2;
  assign RspTag   = tag_p1;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural zero-delay ALU.
module tb_alu_issue_ctrl;

  localparam int N = 64;
  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          Reset, ReqValid, ReqReady, RspReady;
  logic [2:0]    ReqOp;
  logic [N-1:0]  ReqA, ReqB, ALUBusA, ALUBusB, ALUBusW, RspData;
  logic [TW-1:0] ReqTag, RspTag;
  logic [3:0]    ALUCtrl;
  logic          ALUZero, RspValid, RspZero, RspTaken, RspErr;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.n(N), .ALU_LAT(2), .TAGW(TW)) dut (
    .CLK(CLK), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqA(ReqA), .ReqB(ReqB), .ReqTag(ReqTag),
    .ALUCtrl(ALUCtrl), .ALUBusA(ALUBusA), .ALUBusB(ALUBusB),
    .ALUBusW(ALUBusW), .ALUZero(ALUZero),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .RspZero(RspZero), .RspTaken(RspTaken), .RspErr(RspErr), .RspTag(RspTag)
  );

  always #5 CLK = ~CLK;

  // Reference ALU
  always_comb begin
    case (ALUCtrl)
      4'b0000: ALUBusW = ALUBusA & ALUBusB;
      4'b0001: ALUBusW = ALUBusA | ALUBusB;
      4'b0010: ALUBusW = ALUBusA + ALUBusB;
      4'b0110: ALUBusW = ALUBusA - ALUBusB;
      4'b0111: ALUBusW = ALUBusB;
      default: ALUBusW = '0;
    endcase
    ALUZero = (ALUBusW == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request and return right after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [TW-1:0] tag);
    int k;
    ReqOp = op; ReqA = a; ReqB = b; ReqTag = tag; ReqValid = 1'b1;
    k = 0;
    while (!ReqReady && k < 20) begin
      tick();
      k++;
    end
    if (!ReqReady) check("req_timeout", 64'd0, 64'd1);
    tick();
    ReqValid = 1'b0;
  endtask

  // Wait for RspValid; lat = number of edges after the accept edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!RspValid && lat < 20) begin
      tick();
      lat++;
    end
    if (!RspValid) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [3:0] exp_ctrl,
                        input logic [N-1:0] exp_data, input logic exp_zero,
                        input logic exp_taken);
    int lat;
    issue(op, a, b, 4'd6);
    check({name, "_ctrl"}, 64'(ALUCtrl), 64'(exp_ctrl));
    wait_rsp(lat);
    check({name, "_data"}, RspData, exp_data);
    check({name, "_zero"}, 64'(RspZero), 64'(exp_zero));
    check({name, "_taken"}, 64'(RspTaken), 64'(exp_taken));
    check({name, "_err"}, 64'(RspErr), 64'd0);
    tick();
  endtask

  initial begin
    int lat;
    logic seen;
    Reset = 1'b1; ReqValid = 1'b0; RspReady = 1'b1;
    ReqOp = 3'b000; ReqA = '0; ReqB = '0; ReqTag = '0;
    tick(); tick();
    check("rst_ctrl", 64'(ALUCtrl), 64'h7);
    check("rst_busa", ALUBusA, 64'd0);
    check("rst_rspvalid", 64'(RspValid), 64'd0);
    check("rst_rspdata", RspData, 64'd0);
    check("rst_reqready", 64'(ReqReady), 64'd1);
    Reset = 1'b0;
    tick();

    // 1: ADD 5+7, tag 3
    issue(3'b010, 64'd5, 64'd7, 4'd3);
    check("add_ctrl", 64'(ALUCtrl), 64'h2);
    check("add_busa", ALUBusA, 64'd5);
    check("add_busb", ALUBusB, 64'd7);
    check("add_exec_reqready", 64'(ReqReady), 64'd0);
    check("add_exec_rspvalid", 64'(RspValid), 64'd0);
    wait_rsp(lat);
    check("add_latency", 64'(lat), 64'd2);
    check("add_data", RspData, 64'd12);
    check("add_zero", 64'(RspZero), 64'd0);
    check("add_tag", 64'(RspTag), 64'd3);
    check("add_err", 64'(RspErr), 64'd0);
    check("add_rsp_reqready", 64'(ReqReady), 64'd1);
    tick();
    check("add_back_idle", 64'(RspValid), 64'd0);

    // 2: SUB
    run_op("sub_eq", 3'b011, 64'd9, 64'd9, 4'h6, 64'd0, 1'b1, 1'b0);
    run_op("sub_wrap", 3'b011, 64'd0, 64'd1, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // 3: branches, plus AND/OR/PASSB
    run_op("cbz0", 3'b101, 64'd123, 64'd0, 4'h7, 64'd0, 1'b1, 1'b1);
    run_op("cbnz0", 3'b110, 64'd123, 64'd0, 4'h7, 64'd0, 1'b1, 1'b0);
    run_op("cbnz4", 3'b110, 64'd123, 64'd4, 4'h7, 64'd4, 1'b0, 1'b1);
    run_op("and", 3'b000, 64'hF0F0, 64'h3C3C, 4'h0, 64'h3030, 1'b0, 1'b0);
    run_op("or", 3'b001, 64'hF000, 64'h000F, 4'h1, 64'hF00F, 1'b0, 1'b0);
    run_op("passb", 3'b100, 64'd77, 64'd55, 4'h7, 64'd55, 1'b0, 1'b0);

    // 4: backpressure with a second request pending
    RspReady = 1'b0;
    issue(3'b010, 64'd10, 64'd20, 4'd1);
    wait_rsp(lat);
    ReqOp = 3'b001; ReqA = 64'd3; ReqB = 64'd5; ReqTag = 4'd2; ReqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(RspValid), 64'd1);
      check("bp_data", RspData, 64'd30);
      check("bp_tag", 64'(RspTag), 64'd1);
      check("bp_reqready", 64'(ReqReady), 64'd0);
    end
    RspReady = 1'b1;
    #1;
    check("b2b_reqready", 64'(ReqReady), 64'd1);
    tick();
    ReqValid = 1'b0;
    check("b2b_rspvalid", 64'(RspValid), 64'd0);
    check("b2b_ctrl", 64'(ALUCtrl), 64'h1);
    check("b2b_busa", ALUBusA, 64'd3);
    wait_rsp(lat);
    check("b2b_latency", 64'(lat), 64'd2);
    check("b2b_data", RspData, 64'd7);
    check("b2b_tag", 64'(RspTag), 64'd2);
    tick();

    // 5: illegal opcode
    issue(3'b111, 64'd1111, 64'd2222, 4'd9);
    check("ill_valid", 64'(RspValid), 64'd1);
    check("ill_err", 64'(RspErr), 64'd1);
    check("ill_data", RspData, 64'd0);
    check("ill_zero", 64'(RspZero), 64'd0);
    check("ill_taken", 64'(RspTaken), 64'd0);
    check("ill_tag", 64'(RspTag), 64'd9);
    check("ill_busa", ALUBusA, 64'd3);
    check("ill_busb", ALUBusB, 64'd5);
    tick();
    check("ill_done", 64'(RspValid), 64'd0);

    // 6: reset mid-operation
    issue(3'b010, 64'd1, 64'd2, 4'd5);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_ctrl", 64'(ALUCtrl), 64'h7);
    check("mid_rst_busa", ALUBusA, 64'd0);
    check("mid_rst_busb", ALUBusB, 64'd0);
    check("mid_rst_tag", 64'(RspTag), 64'd0);
    check("mid_rst_reqready", 64'(ReqReady), 64'd1);
    seen = RspValid;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | RspValid;
    end
    check("mid_rst_no_rsp", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
